// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetch buffer between the core fetch port and the memory bridge.
// Define IPB_PAGE_STOP_EN to stop prefetching at the last word of each 1 KiB page.
module instr_prefetch_buf #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = ADDR_WIDTH - 2;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [WW-1:0]        r_head;
    logic [WW-1:0]        r_fetch;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_inflight;
    logic [CW-1:0]        r_discard;
    logic [CW-1:0]        w_count_nxt;
    logic [CW-1:0]        w_inflight_nxt;
    logic [CW-1:0]        w_discard_nxt;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                 r_rvalid;
    logic                 r_pend;
    logic                 r_pend_stale;
    logic [WW-1:0]        r_pend_addr;

    logic                 w_run;
    logic                 w_match;
    logic                 w_hit;
    logic                 w_wait;
    logic                 w_miss;
    logic                 w_restart;
    logic                 w_page_stop;
    logic [CW:0]          w_used;
    logic                 w_issue;
    logic [WW-1:0]        w_mem_word;
    logic                 w_mem_fire;
    logic                 w_stale_fire;
    logic                 w_live_fire;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_unused;

    assign w_unused = ^core_addr_i[1:0];

    assign w_run   = (r_state == StRun);
    assign w_match = (core_addr_i[ADDR_WIDTH-1:2] == r_head);
    assign w_hit   = core_req_i && w_run && w_match && (r_count != '0);
    // An empty buffer on the head address always has the head word on its way or about
    // to be requested, so the core just waits instead of restarting the stream.
    assign w_wait  = core_req_i && w_run && w_match && (r_count == '0) && !w_restart;
    assign w_miss  = core_req_i && !w_hit && !w_wait;

    assign w_used  = {1'b0, r_count} + {1'b0, r_inflight} + {1'b0, r_discard};
    assign w_issue = w_run && (w_used < DEPTH_L) && !w_page_stop;

    assign w_mem_fire   = mem_req_o && mem_gnt_i;
    assign w_stale_fire = w_mem_fire && r_pend && r_pend_stale;
    assign w_live_fire  = w_mem_fire && !(r_pend && r_pend_stale) && !w_miss;
    assign w_drop       = mem_rvalid_i && (r_discard != '0);
    assign w_push       = mem_rvalid_i && (r_discard == '0) && !w_miss;

`ifdef IPB_PAGE_STOP_EN
    logic r_page_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page_stop <= 1'b0;
        end else if (w_miss) begin
            r_page_stop <= 1'b0;
        end else if (w_live_fire && (&w_mem_word[7:0])) begin
            r_page_stop <= 1'b1;
        end
    end

    assign w_page_stop = r_page_stop;
    // Stream drained up to the page end: the core reaching the next page restarts it.
    assign w_restart   = r_page_stop && (r_count == '0) && (r_inflight == '0);
`else
    assign w_page_stop = 1'b0;
    assign w_restart   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (core_req_i) w_state_nxt = StRun;
            StRun:   w_state_nxt = StRun;
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM outputs; a pending downstream request keeps its address until granted
    always_comb begin
        core_gnt_o = 1'b0;
        mem_req_o  = 1'b0;
        w_mem_word = r_fetch;
        if (r_state == StRun) begin
            core_gnt_o = w_hit;
        end
        mem_req_o = r_pend || w_issue;
        if (r_pend) begin
            w_mem_word = r_pend_addr;
        end
    end

    assign mem_addr_o    = {w_mem_word, 2'b00};
    assign core_rvalid_o = r_rvalid;
    assign core_rdata_o  = r_rdata;

    // A flush folds every outstanding old-stream word, including one granted now, into discard.
    always_comb begin
        w_count_nxt    = r_count;
        w_inflight_nxt = r_inflight;
        w_discard_nxt  = r_discard;
        if (w_miss) begin
            w_count_nxt    = '0;
            w_inflight_nxt = '0;
            w_discard_nxt  = r_discard + r_inflight + CW'(w_mem_fire) - CW'(mem_rvalid_i);
        end else begin
            w_count_nxt    = r_count + CW'(w_push) - CW'(w_hit);
            w_inflight_nxt = r_inflight + CW'(w_live_fire) - CW'(w_push);
            w_discard_nxt  = r_discard + CW'(w_stale_fire) - CW'(w_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_head       <= '0;
            r_fetch      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_stale <= 1'b0;
            r_pend_addr  <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
            r_rvalid   <= w_hit;

            if (w_miss) begin
                r_head   <= core_addr_i[ADDR_WIDTH-1:2];
                r_fetch  <= core_addr_i[ADDR_WIDTH-1:2];
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_hit) begin
                    r_head   <= r_head + 1'b1;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_live_fire) begin
                    r_fetch <= r_fetch + 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end

            if (w_hit) begin
                r_rdata <= r_fifo[r_rd_ptr];
            end

            r_pend       <= mem_req_o && !mem_gnt_i;
            r_pend_addr  <= w_mem_word;
            r_pend_stale <= mem_req_o && !mem_gnt_i && ((r_pend && r_pend_stale) || w_miss);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Directed bench for instr_prefetch_buf: streaming, flush, backpressure, full, wrap, async reset.
module tb_instr_prefetch_buf;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] B     = 32'h1000_0000;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        core_req_i   = 1'b0;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [31:0] core_addr_i  = '0;
    logic [31:0] core_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i  = '0;

    logic        gnt_en  = 1'b1;
    logic        resp_en = 1'b1;
    logic [31:0] pq[$];
    logic [31:0] gq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    assign mem_gnt_i = gnt_en;

    instr_prefetch_buf #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_addr_i   (core_addr_i),
        .core_rdata_o  (core_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // In-order memory: one response per cycle from the grant queue while resp_en is high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
            pq.delete();
        end else begin
            if (mem_req_o && mem_gnt_i) begin
                pq.push_back(mem_addr_o);
                gq.push_back(mem_addr_o);
            end
            if (resp_en && pq.size() > 0) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= memf(pq.pop_front());
            end else begin
                mem_rvalid_i <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            assert (32'(dut.r_count) + 32'(dut.r_inflight) + 32'(dut.r_discard) <= DEPTH)
            else begin
                n_errors++;
                $error("FAIL credit: used=%0d limit=%0d",
                       32'(dut.r_count) + 32'(dut.r_inflight) + 32'(dut.r_discard), DEPTH);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (core_gnt_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          idx;
        logic [31:0] wa [5];
        wa[0] = 32'hFFFF_FFF8;
        wa[1] = 32'hFFFF_FFFC;
        wa[2] = 32'h0000_0000;
        wa[3] = 32'h0000_0004;
        wa[4] = 32'h0000_0008;

        // Reset values
        @(negedge clk); #1;
        check("rst_gnt", 32'(core_gnt_o), 0);
        check("rst_rvalid", 32'(core_rvalid_o), 0);
        check("rst_rdata", core_rdata_o, 0);
        check("rst_mem_req", 32'(mem_req_o), 0);
        check("rst_mem_addr", mem_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential stream, zero-wait memory
        @(negedge clk);
        core_req_i = 1'b1; core_addr_i = B; #1;
        check("seq_miss_gnt", 32'(core_gnt_o), 0);
        wait_gnt(cyc);
        check("seq_first_lat", cyc, 3);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            core_addr_i = B + 32'(4 * i); #1;
            check("seq_rvalid", 32'(core_rvalid_o), 1);
            check("seq_rdata", core_rdata_o, memf(B + 32'(4 * (i - 1))));
            check("seq_gnt", 32'(core_gnt_o), 1);
        end
        @(negedge clk);
        core_req_i = 1'b0; #1;
        check("seq_last_rvalid", 32'(core_rvalid_o), 1);
        check("seq_last_rdata", core_rdata_o, memf(B + 32'h1C));

        // Full: prefetch stops DEPTH words ahead of the head
        repeat (6) @(negedge clk);
        #1;
        check("full_req_off", 32'(mem_req_o), 0);
        check("full_n_grants", gq.size(), 12);
        check("full_last_addr", gq[11], B + 32'h2C);
        @(negedge clk);
        core_req_i = 1'b1; core_addr_i = B + 32'h20; #1;
        check("full_hit_gnt", 32'(core_gnt_o), 1);
        @(negedge clk);
        core_req_i = 1'b0; #1;
        check("full_hit_rdata", core_rdata_o, memf(B + 32'h20));
        check("full_refill_req", 32'(mem_req_o), 1);
        check("full_refill_addr", mem_addr_o, B + 32'h30);
        @(negedge clk); #1;
        check("full_one_only", 32'(mem_req_o), 0);
        check("full_n_grants2", gq.size(), 13);

        // Branch flush with three words in flight
        @(negedge clk);
        resp_en = 1'b0; core_req_i = 1'b1; core_addr_i = B + 32'h24; #1;
        check("fl_hit24_gnt", 32'(core_gnt_o), 1);
        @(negedge clk);
        core_addr_i = B + 32'h28; #1;
        check("fl_hit28_gnt", 32'(core_gnt_o), 1);
        check("fl_rdata24", core_rdata_o, memf(B + 32'h24));
        @(negedge clk);
        core_addr_i = B + 32'h2C; #1;
        check("fl_hit2c_gnt", 32'(core_gnt_o), 1);
        check("fl_rdata28", core_rdata_o, memf(B + 32'h28));
        @(negedge clk);
        core_req_i = 1'b0; #1;
        check("fl_rdata2c", core_rdata_o, memf(B + 32'h2C));
        @(negedge clk);
        @(negedge clk); #1;
        check("fl_req_off", 32'(mem_req_o), 0);
        check("fl_n_grants", gq.size(), 16);
        check("fl_last_inflight", gq[15], B + 32'h3C);
        @(negedge clk);
        idx = gq.size();
        core_req_i = 1'b1; core_addr_i = B + 32'h200; resp_en = 1'b1; #1;
        check("fl_miss_gnt", 32'(core_gnt_o), 0);
        wait_gnt(cyc);
        check("fl_lat", cyc, 5);
        @(negedge clk);
        core_req_i = 1'b0; #1;
        check("fl_rvalid", 32'(core_rvalid_o), 1);
        check("fl_rdata", core_rdata_o, memf(B + 32'h200));
        repeat (6) @(negedge clk);
        #1;
        check("fl_addr0", gq[idx], B + 32'h200);
        check("fl_addr1", gq[idx + 1], B + 32'h204);
        check("fl_addr2", gq[idx + 2], B + 32'h208);

        // Backpressure: request held stable, then a miss turns it into a discard
        @(negedge clk);
        gnt_en = 1'b0; core_req_i = 1'b1; core_addr_i = B + 32'h40; #1;
        check("bp_miss_gnt", 32'(core_gnt_o), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("bp_req", 32'(mem_req_o), 1);
            check("bp_addr", mem_addr_o, B + 32'h40);
        end
        @(negedge clk);
        core_addr_i = B + 32'h80; #1;
        check("bp_miss2_gnt", 32'(core_gnt_o), 0);
        check("bp_addr_flush", mem_addr_o, B + 32'h40);
        @(negedge clk); #1;
        check("bp_req_held", 32'(mem_req_o), 1);
        check("bp_addr_held", mem_addr_o, B + 32'h40);
        @(negedge clk);
        gnt_en = 1'b1; #1;
        check("bp_stale_addr", mem_addr_o, B + 32'h40);
        @(negedge clk); #1;
        check("bp_new_req", 32'(mem_req_o), 1);
        check("bp_new_addr", mem_addr_o, B + 32'h80);
        wait_gnt(cyc);
        check("bp_gnt_seen", 32'(core_gnt_o), 1);
        @(negedge clk);
        core_req_i = 1'b0; #1;
        check("bp_rdata", core_rdata_o, memf(B + 32'h80));

        // Address wrap with simultaneous push and pop
        repeat (6) @(negedge clk);
        idx = gq.size();
        core_req_i = 1'b1; core_addr_i = wa[0]; #1;
        check("wr_miss_gnt", 32'(core_gnt_o), 0);
        wait_gnt(cyc);
        check("wr_lat", cyc, 3);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            core_addr_i = wa[i]; #1;
            check("wr_gnt", 32'(core_gnt_o), 1);
            check("wr_rvalid", 32'(core_rvalid_o), 1);
            check("wr_rdata", core_rdata_o, memf(wa[i - 1]));
        end
        check("wr_addr0", gq[idx], 32'hFFFF_FFF8);
        check("wr_addr1", gq[idx + 1], 32'hFFFF_FFFC);
        check("wr_addr2", gq[idx + 2], 32'h0000_0000);

        // Asynchronous reset between edges
        #1;
        rst_n = 1'b0; #1;
        check("ar_gnt", 32'(core_gnt_o), 0);
        check("ar_rvalid", 32'(core_rvalid_o), 0);
        check("ar_mem_req", 32'(mem_req_o), 0);
        @(negedge clk);
        rst_n = 1'b1; core_addr_i = B + 32'h100; #1;
        check("ar_first_miss", 32'(core_gnt_o), 0);
        wait_gnt(cyc);
        check("ar_lat", cyc, 3);
        @(negedge clk);
        core_req_i = 1'b0; #1;
        check("ar_rdata", core_rdata_o, memf(B + 32'h100));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
